// File: rtl/potential_accumulator_pkg.sv
// Shared types and float32 constants for the neuron membrane loop
// (accumulator, decay stage, spike generator).
package potential_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_OUT     = 2'd3
  } acc_state_t;

  localparam logic [31:0] FP_POS_ZERO   = 32'h0000_0000;
  localparam logic [7:0]  FP_EXP_MAX    = 8'hFF;
  localparam logic [31:0] DEF_THRESHOLD = 32'h41A0_0000;  // 20.0
  localparam logic [31:0] DEF_V_RESET   = 32'h0000_0000;  // +0.0

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// Exception flags an Inf/NaN operand or a result that overflows the exponent range.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic        b_sign, swap, big_s, small_s, eff_sub, sticky, round_up, in_exc;
  logic [7:0]  big_e, small_e, big_ee, small_ee, diff, exp_field;
  logic [23:0] big_m, small_m;
  logic [26:0] small_ext, shifted, mask, norm;
  logic [27:0] sum;
  logic [9:0]  exp_w;
  logic [4:0]  lead, shamt;
  logic [24:0] rnd;

  always_comb begin
    b_sign    = b_operand[31] ^ AddBar_Sub;
    swap      = b_operand[30:0] > a_operand[30:0];
    big_s     = swap ? b_sign : a_operand[31];
    small_s   = swap ? a_operand[31] : b_sign;
    big_e     = swap ? b_operand[30:23] : a_operand[30:23];
    small_e   = swap ? a_operand[30:23] : b_operand[30:23];
    big_m     = {(big_e != 8'd0), (swap ? b_operand[22:0] : a_operand[22:0])};
    small_m   = {(small_e != 8'd0), (swap ? a_operand[22:0] : b_operand[22:0])};
    // Denormals share the exponent of the smallest normal.
    big_ee    = (big_e == 8'd0) ? 8'd1 : big_e;
    small_ee  = (small_e == 8'd0) ? 8'd1 : small_e;
    diff      = big_ee - small_ee;
    small_ext = {small_m, 3'b000};
    shifted   = '0;
    mask      = '0;
    sticky    = 1'b0;
    if (diff >= 8'd27) begin
      sticky = |small_m;
    end else begin
      shifted = small_ext >> diff;
      mask    = (27'd1 << diff) - 27'd1;
      sticky  = |(small_ext & mask);
    end
    eff_sub = big_s ^ small_s;
    if (eff_sub)
      sum = {1'b0, big_m, 3'b000} - {1'b0, shifted[26:1], shifted[0] | sticky};
    else
      sum = {1'b0, big_m, 3'b000} + {1'b0, shifted[26:1], shifted[0] | sticky};

    exp_w = {2'b00, big_ee};
    lead  = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lead = i[4:0];
    end
    shamt = 5'd0;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_w = exp_w + 10'd1;
    end else begin
      shamt = 5'd26 - lead;
      // Stop normalising at the denormal boundary.
      if ({5'd0, shamt} >= exp_w) shamt = exp_w[4:0] - 5'd1;
      norm  = sum[26:0] << shamt;
      exp_w = exp_w - {5'd0, shamt};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      rnd   = {1'b0, rnd[24:1]};
      exp_w = exp_w + 10'd1;
    end
    exp_field = rnd[23] ? exp_w[7:0] : 8'd0;

    in_exc    = (&a_operand[30:23]) | (&b_operand[30:23]);
    Exception = in_exc | (exp_w >= 10'd255);
    if (in_exc)
      result = 32'h7FC0_0000;
    else if (exp_w >= 10'd255)
      result = {big_s, 8'hFF, 23'd0};
    else if (sum == 28'd0)
      result = {big_s & small_s, 31'd0};
    else
      result = {big_s, exp_field, rnd[22:0]};
  end

endmodule

// File: rtl/fp32_ge.sv
// Combinational float32 a >= b: +0 equals -0, any NaN operand compares false.
module fp32_ge
  import potential_accumulator_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ge_o
);

  logic a_zero, b_zero;

  always_comb begin
    a_zero = (a_i[30:0] == 31'd0);
    b_zero = (b_i[30:0] == 31'd0);
    if (fp_is_nan(a_i) || fp_is_nan(b_i))
      ge_o = 1'b0;
    else if (a_zero && b_zero)
      ge_o = 1'b1;
    else if (a_i[31] != b_i[31])
      ge_o = ~a_i[31];
    else if (!a_i[31])
      ge_o = (a_i[30:0] >= b_i[30:0]);
    else
      ge_o = (a_i[30:0] <= b_i[30:0]);
  end

endmodule

// File: rtl/potential_accumulator.sv
// Per-neuron membrane accumulator: loads the decayed potential, sums weights,
// fires against THRESHOLD and hands the new potential back to the decay stage.
module potential_accumulator
  import potential_accumulator_pkg::*;
#(
  parameter logic [31:0] THRESHOLD   = DEF_THRESHOLD,
  parameter logic [31:0] V_RESET     = DEF_V_RESET,
  parameter logic [11:0] NEURON_ADDR = 12'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        decay_valid,
  input  logic [31:0] decay_potential,
  input  logic        w_valid,
  input  logic [31:0] w_data,
  output logic        w_ready,
  input  logic        ts_end,
  output logic [31:0] new_potential,
  output logic        pot_valid,
  input  logic        pot_ready,
  output logic        spike,
  output logic [11:0] spike_addr,
  output logic        err
);

  acc_state_t  state_q;
  logic [31:0] acc_q, acc_d, new_pot_q, add_sum;
  logic        w_ready_q, pot_valid_q, spike_q, err_q;
  logic [11:0] spike_addr_q;
  logic        add_exc, w_take, fire_d;

  assign w_take = (state_q == ST_ACCUM) && w_valid;

  Addition_Subtraction u_add (
    .a_operand  (acc_q),
    .b_operand  (w_data),
    .AddBar_Sub (1'b0),
    .Exception  (add_exc),
    .result     (add_sum)
  );

  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_IDLE && decay_valid)
      acc_d = decay_potential;
    else if (w_take && !add_exc)
      acc_d = add_sum;
  end

  // Comparing the post-update value lets spike be registered on the ts_end edge
  // and still reflect a weight accepted in that same cycle.
  fp32_ge u_ge (
    .a_i  (acc_d),
    .b_i  (THRESHOLD),
    .ge_o (fire_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      acc_q        <= FP_POS_ZERO;
      new_pot_q    <= FP_POS_ZERO;
      w_ready_q    <= 1'b0;
      pot_valid_q  <= 1'b0;
      spike_q      <= 1'b0;
      spike_addr_q <= 12'd0;
      err_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      spike_q      <= 1'b0;
      spike_addr_q <= 12'd0;
      if (w_take && add_exc) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (decay_valid) begin
            state_q   <= ST_ACCUM;
            w_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (ts_end) begin
            state_q      <= ST_COMPARE;
            w_ready_q    <= 1'b0;
            spike_q      <= fire_d;
            spike_addr_q <= fire_d ? NEURON_ADDR : 12'd0;
          end
        end
        ST_COMPARE: begin
          new_pot_q   <= spike_q ? V_RESET : acc_q;
          pot_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (pot_ready) begin
            pot_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_ready       = w_ready_q;
  assign new_potential = new_pot_q;
  assign pot_valid     = pot_valid_q;
  assign spike         = spike_q;
  assign spike_addr    = spike_addr_q;
  assign err           = err_q;

endmodule

// File: tb/tb_potential_accumulator.sv
// Directed bench for potential_accumulator; inputs change and outputs are sampled on falling edges.
module tb_potential_accumulator;

  localparam logic [11:0] ADDR = 12'hA5C;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        decay_valid = 1'b0;
  logic [31:0] decay_potential = 32'd0;
  logic        w_valid = 1'b0;
  logic [31:0] w_data = 32'd0;
  logic        w_ready;
  logic        ts_end = 1'b0;
  logic [31:0] new_potential;
  logic        pot_valid;
  logic        pot_ready = 1'b0;
  logic        spike;
  logic [11:0] spike_addr;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  potential_accumulator #(
    .THRESHOLD   (32'h41A0_0000),
    .V_RESET     (32'h0000_0000),
    .NEURON_ADDR (ADDR)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .decay_valid     (decay_valid),
    .decay_potential (decay_potential),
    .w_valid         (w_valid),
    .w_data          (w_data),
    .w_ready         (w_ready),
    .ts_end          (ts_end),
    .new_potential   (new_potential),
    .pot_valid       (pot_valid),
    .pot_ready       (pot_ready),
    .spike           (spike),
    .spike_addr      (spike_addr),
    .err             (err)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drives one decay strobe; returns with the DUT in ACCUM.
  task automatic load(input logic [31:0] v);
    decay_valid = 1'b1;
    decay_potential = v;
    tick();
    decay_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL rst_w_ready: got %b want 0", w_ready); end
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL rst_pot_valid: got %b want 0", pot_valid); end
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL rst_spike: got %b want 0", spike); end
    checks++; if (spike_addr !== 12'd0) begin errors++; $display("FAIL rst_spike_addr: got %h want 000", spike_addr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (new_potential !== 32'd0) begin errors++; $display("FAIL rst_new_potential: got %h want 00000000", new_potential); end
    RST = 1'b0;
    ts_end = 1'b1;
    w_valid = 1'b1;
    w_data = 32'h4080_0000;
    tick();
    ts_end = 1'b0;
    w_valid = 1'b0;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL idle_w_ready: got %b want 0", w_ready); end
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL idle_ts_end_spike: got %b want 0", spike); end
    tick();
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL idle_ts_end_pot_valid: got %b want 0", pot_valid); end
  endtask

  task automatic test_no_spike();
    load(32'h4140_0000);
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL accum_w_ready: got %b want 1", w_ready); end
    w_valid = 1'b1;
    w_data = 32'h4080_0000;
    tick();
    w_valid = 1'b0;
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL nospike_spike: got %b want 0", spike); end
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL nospike_pot_valid_early: got %b want 0", pot_valid); end
    tick();
    checks++; if (pot_valid !== 1'b1) begin errors++; $display("FAIL nospike_pot_valid: got %b want 1", pot_valid); end
    checks++; if (new_potential !== 32'h4180_0000) begin errors++; $display("FAIL nospike_new_potential: got %h want 41800000", new_potential); end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL nospike_pot_release: got %b want 0", pot_valid); end
  endtask

  task automatic test_threshold_equal();
    load(32'h4140_0000);
    w_valid = 1'b1;
    w_data = 32'h4100_0000;
    tick();
    w_valid = 1'b0;
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++; if (spike !== 1'b1) begin errors++; $display("FAIL eq_spike: got %b want 1", spike); end
    checks++; if (spike_addr !== ADDR) begin errors++; $display("FAIL eq_spike_addr: got %h want %h", spike_addr, ADDR); end
    tick();
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL eq_spike_one_cycle: got %b want 0", spike); end
    checks++; if (pot_valid !== 1'b1) begin errors++; $display("FAIL eq_pot_valid: got %b want 1", pot_valid); end
    checks++; if (new_potential !== 32'h0000_0000) begin errors++; $display("FAIL eq_new_potential: got %h want 00000000", new_potential); end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws [3];
    ws[0] = 32'h4100_0000;
    ws[1] = 32'hC040_0000;
    ws[2] = 32'h4000_0000;
    load(32'h4140_0000);
    w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_data = ws[i];
      ts_end = (i == 2);
      checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL b2b_w_ready[%0d]: got %b want 1", i, w_ready); end
      tick();
    end
    w_valid = 1'b0;
    ts_end = 1'b0;
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL b2b_spike: got %b want 0", spike); end
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL b2b_compare_w_ready: got %b want 0", w_ready); end
    tick();
    checks++; if (new_potential !== 32'h4198_0000) begin errors++; $display("FAIL b2b_new_potential: got %h want 41980000", new_potential); end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
  endtask

  task automatic test_zero_weights();
    load(32'h41C8_0000);
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++; if (spike !== 1'b1) begin errors++; $display("FAIL zw_spike: got %b want 1", spike); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pot_valid !== 1'b1) begin errors++; $display("FAIL zw_hold_pot_valid[%0d]: got %b want 1", i, pot_valid); end
      checks++; if (new_potential !== 32'h0000_0000) begin errors++; $display("FAIL zw_hold_new_potential[%0d]: got %h want 00000000", i, new_potential); end
    end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL zw_pot_release: got %b want 0", pot_valid); end
  endtask

  task automatic test_exception();
    load(32'h7F7F_FFFF);
    w_valid = 1'b1;
    w_data = 32'h7F7F_FFFF;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL exc_err: got %b want 1", err); end
    // Cancels the held max exactly; a corrupted acc would land elsewhere.
    w_data = 32'hFF7F_FFFF;
    tick();
    w_valid = 1'b0;
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL exc_spike: got %b want 0", spike); end
    tick();
    checks++; if (new_potential !== 32'h0000_0000) begin errors++; $display("FAIL exc_new_potential: got %h want 00000000", new_potential); end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
  endtask

  task automatic test_nan();
    load(32'h7FC0_0000);
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL nan_spike: got %b want 0", spike); end
    tick();
    checks++; if (new_potential !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_new_potential: got %h want 7fc00000", new_potential); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL nan_err_sticky: got %b want 1", err); end
    pot_ready = 1'b1;
    tick();
    pot_ready = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    load(32'h4140_0000);
    w_valid = 1'b1;
    w_data = 32'h4100_0000;
    tick();
    tick();
    w_valid = 1'b0;
    RST = 1'b1;
    #1;
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_w_ready: got %b want 0", w_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", err); end
    checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_pot_valid: got %b want 0", pot_valid); end
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL mid_rst_spike: got %b want 0", spike); end
    tick();
    RST = 1'b0;
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (spike !== 1'b0) begin errors++; $display("FAIL post_rst_spike[%0d]: got %b want 0", i, spike); end
      checks++; if (pot_valid !== 1'b0) begin errors++; $display("FAIL post_rst_pot_valid[%0d]: got %b want 0", i, pot_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_no_spike();
    test_threshold_equal();
    test_back_to_back();
    test_zero_weights();
    test_exception();
    test_nan();
    test_reset_mid_accum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
